result_serializer: RTL and testbench



---
 rtl/result_serializer_pkg.sv | 26 ++
 rtl/result_serializer_if.sv | 39 +++
 rtl/result_serializer_fifo.sv | 65 ++++++
 rtl/result_serializer.sv | 131 +++++++++++++
 tb/tb_result_serializer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/result_serializer_pkg.sv
// Shared constants, FSM state type and entry-select helper for the result serializer.
// Optional drop counter is enabled by defining RESULT_SERIALIZER_DROPCNT_EN.
package result_serializer_pkg;

    localparam int ELEM_W     = 6;
    localparam int N_ELEM     = 4;
    localparam int TAG_W      = 4;
    localparam int RESULT_W   = ELEM_W * N_ELEM;
    localparam int IDX_W      = 2;
    localparam int FIFO_DEPTH = 2;
    localparam int DROP_W     = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Entry k lives in bits [ELEM_W*k +: ELEM_W]; entry 0 is the least significant.
    function automatic logic [ELEM_W-1:0] entry_sel(
        input logic [RESULT_W-1:0] word,
        input logic [IDX_W-1:0]    idx
    );
        return word[int'(idx)*ELEM_W +: ELEM_W];
    endfunction

endpackage

// File: rtl/result_serializer_if.sv
// Handshake bundle between the matrix multiplier, the serializer and its narrow consumer.
// The drop_count field exists only when RESULT_SERIALIZER_DROPCNT_EN is defined.
interface result_serializer_if;
    import result_serializer_pkg::*;

    logic                in_valid;
    logic [RESULT_W-1:0] matrix_result;
    logic [TAG_W-1:0]    matrix_count;

    logic                out_valid;
    logic                out_ready;
    logic [ELEM_W-1:0]   out_data;
    logic [IDX_W-1:0]    out_index;
    logic [TAG_W-1:0]    out_tag;
    logic                out_last;
    logic                overflow;
`ifdef RESULT_SERIALIZER_DROPCNT_EN
    logic [DROP_W-1:0]   drop_count;

    modport slave (
        input  in_valid, matrix_result, matrix_count, out_ready,
        output out_valid, out_data, out_index, out_tag, out_last, overflow, drop_count
    );
    modport master (
        output in_valid, matrix_result, matrix_count, out_ready,
        input  out_valid, out_data, out_index, out_tag, out_last, overflow, drop_count
    );
`else
    modport slave (
        input  in_valid, matrix_result, matrix_count, out_ready,
        output out_valid, out_data, out_index, out_tag, out_last, overflow
    );
    modport master (
        output in_valid, matrix_result, matrix_count, out_ready,
        input  out_valid, out_data, out_index, out_tag, out_last, overflow
    );
`endif

endinterface

// File: rtl/result_serializer_fifo.sv
// result_fifo: DEPTH-entry word+tag FIFO; push and pop may coincide even when full.
// Storage is not reset; only pointers and count are.
module result_fifo #(
    parameter  int DEPTH = 2,
    parameter  int W     = 28,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/result_serializer.sv
// Buffers completed result matrices with their tag and streams them out one entry per beat.
// Define RESULT_SERIALIZER_DROPCNT_EN to add a saturating drop_count output.
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int WORD_W = RESULT_W + TAG_W
) (
    input  logic                  clock,
    input  logic                  reset,
    result_serializer_if.slave    io
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               send;
    logic               beat;
    logic               last_beat;
    logic               push_ok;
    logic               drop;

    logic [WORD_W-1:0]  head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_cnt;

    result_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_ok),
        .pop   (last_beat),
        .din   ({io.matrix_count, io.matrix_result}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign send = (state_q == SEND);

    always_comb begin
        beat      = send && !fifo_empty && io.out_ready;
        last_beat = beat && (idx_q == IDX_W'(N_ELEM - 1));
        // A full FIFO still takes a word when the head leaves in the same cycle.
        push_ok   = io.in_valid && (!fifo_full || last_beat);
        drop      = io.in_valid && !push_ok;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (beat) begin
            idx_d = last_beat ? '0 : idx_q + IDX_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (push_ok) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_beat && !push_ok && (fifo_cnt == CNT_W'(1))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

`ifdef RESULT_SERIALIZER_DROPCNT_EN
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign io.drop_count = drop_cnt_q;
    assign io.overflow   = (drop_cnt_q != '0);
`else
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign io.overflow = overflow_q;
`endif

    // Payload fields read as zero whenever nothing is being offered.
    always_comb begin
        io.out_valid = send;
        io.out_data  = send ? entry_sel(head[RESULT_W-1:0], idx_q) : '0;
        io.out_index = send ? idx_q : '0;
        io.out_tag   = send ? head[WORD_W-1:RESULT_W] : '0;
        io.out_last  = send && (idx_q == IDX_W'(N_ELEM - 1));
    end

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: queue-based reference model plus directed literal checks.
module tb_result_serializer;
    import result_serializer_pkg::*;

    localparam int MDEPTH = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    result_serializer_if bus ();

    result_serializer #(.DEPTH(MDEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [RESULT_W-1:0] w;
        logic [TAG_W-1:0]    t;
    } mword_t;

    mword_t mq[$];
    int     mk;
    bit     m_ovf;
    int     m_drops;

    // Reference model: a queue of whole words and a count of entries already sent from the head.
    always @(posedge clock or posedge reset) begin : model
        int  pre;
        bit  popped;
        if (reset) begin
            mq.delete();
            mk      = 0;
            m_ovf   = 0;
            m_drops = 0;
        end else begin
            pre    = mq.size();
            popped = 0;
            if (pre > 0 && bus.out_ready) begin
                mk++;
                if (mk == N_ELEM) begin
                    mk = 0;
                    void'(mq.pop_front());
                    popped = 1;
                end
            end
            if (bus.in_valid) begin
                if (pre < MDEPTH || popped) begin
                    mq.push_back({bus.matrix_result, bus.matrix_count});
                end else begin
                    m_ovf = 1;
                    if (m_drops < 15) m_drops++;
                end
            end
        end
    end

    always @(negedge clock) begin : compare
        logic [RESULT_W-1:0] w;
        bit exp_v;
        exp_v = (mq.size() > 0);
        chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
        if (exp_v) begin
            w = mq[0].w;
            chk("out_data",  32'(bus.out_data),  32'(w[mk*ELEM_W +: ELEM_W]));
            chk("out_index", 32'(bus.out_index), 32'(mk));
            chk("out_tag",   32'(bus.out_tag),   32'(mq[0].t));
            chk("out_last",  32'(bus.out_last),  32'(mk == N_ELEM - 1));
        end else begin
            chk("idle_fields_zero",
                32'({bus.out_data, bus.out_index, bus.out_tag, bus.out_last}), 32'(0));
        end
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
`ifdef RESULT_SERIALIZER_DROPCNT_EN
        chk("drop_count", 32'(bus.drop_count), 32'(m_drops));
`endif
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push(input logic [RESULT_W-1:0] w, input logic [TAG_W-1:0] t);
        bus.in_valid      = 1'b1;
        bus.matrix_result = w;
        bus.matrix_count  = t;
        tick();
        bus.in_valid      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic expect_word_1234(input string tag);
        for (int i = 0; i < N_ELEM; i++) begin
            chk({tag, "_data"},  32'(bus.out_data),  32'(i + 1));
            chk({tag, "_index"}, 32'(bus.out_index), 32'(i));
            chk({tag, "_last"},  32'(bus.out_last),  32'(i == N_ELEM - 1));
            chk({tag, "_tag"},   32'(bus.out_tag),   32'(1));
            tick();
        end
        chk({tag, "_done"}, 32'(bus.out_valid), 32'(0));
    endtask

    initial begin
        bus.in_valid      = 1'b0;
        bus.matrix_result = '0;
        bus.matrix_count  = '0;
        bus.out_ready     = 1'b0;
        reset             = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        chk("rst_valid",    32'(bus.out_valid), 32'(0));
        chk("rst_overflow", 32'(bus.overflow),  32'(0));
        chk("rst_fields",   32'({bus.out_data, bus.out_index, bus.out_tag, bus.out_last}), 32'(0));
        reset = 1'b0;
        tick();

        // Straight-through word: entries 1,2,3,4
        bus.out_ready = 1'b1;
        push(24'h103081, 4'h1);
        expect_word_1234("t1");

        // Stall on entry 0, then drain
        bus.out_ready = 1'b0;
        push(24'h103081, 4'h1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(bus.out_valid), 32'(1));
            chk("stall_data",  32'(bus.out_data),  32'(1));
            chk("stall_index", 32'(bus.out_index), 32'(0));
            tick();
        end
        bus.out_ready = 1'b1;
        expect_word_1234("t2");

        // Third push into a full FIFO is dropped
        bus.out_ready = 1'b0;
        push(24'h041041, 4'h1);
        push(24'h082082, 4'h2);
        push(24'h0C30C3, 4'h3);
        chk("ovf_set", 32'(bus.overflow), 32'(1));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_tag", 32'(bus.out_tag), 32'(i < 4 ? 1 : 2));
            tick();
        end
        chk("ovf_drained", 32'(bus.out_valid), 32'(0));
        chk("ovf_sticky",  32'(bus.overflow),  32'(1));

        // Push coinciding with the last beat of a full FIFO is accepted
        do_reset();
        chk("ovf_cleared", 32'(bus.overflow), 32'(0));
        bus.out_ready = 1'b0;
        push(24'h041041, 4'h1);
        push(24'h082082, 4'h2);
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("full_last_index", 32'(bus.out_index), 32'(3));
        push(24'h145145, 4'h5);
        chk("full_no_ovf", 32'(bus.overflow), 32'(0));
        for (int i = 0; i < 8; i++) begin
            chk("full_tag", 32'(bus.out_tag), 32'(i < 4 ? 2 : 5));
            if (i >= 4) chk("full_new_data", 32'(bus.out_data), 32'(5));
            tick();
        end
        chk("full_drained", 32'(bus.out_valid), 32'(0));

        // Reset in the middle of a word
        push(24'h103081, 4'h7);
        tick();
        tick();
        chk("mid_index", 32'(bus.out_index), 32'(2));
        #1 reset = 1'b1;
        #1 chk("mid_async_valid", 32'(bus.out_valid), 32'(0));
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_idle", 32'(bus.out_valid), 32'(0));
            tick();
        end
        push(24'h103081, 4'h8);
        chk("post_rst_valid", 32'(bus.out_valid), 32'(1));
        chk("post_rst_index", 32'(bus.out_index), 32'(0));
        chk("post_rst_data",  32'(bus.out_data),  32'(1));
        repeat (4) tick();
        chk("post_rst_done",  32'(bus.out_valid), 32'(0));

`ifdef RESULT_SERIALIZER_DROPCNT_EN
        // Saturating drop counter
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            push(24'h000001 + 24'(i), 4'(i));
            if (i == 2) chk("dc_one", 32'(bus.drop_count), 32'(1));
        end
        chk("dc_sat",      32'(bus.drop_count), 32'(15));
        chk("dc_overflow", 32'(bus.overflow),   32'(1));
        bus.out_ready = 1'b1;
        repeat (8) tick();
        chk("dc_drained",  32'(bus.out_valid),  32'(0));
        chk("dc_held",     32'(bus.drop_count), 32'(15));
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
